// File: rtl/sfu_accum.sv
// sfu_accum: accumulates OFIFO psum rows across kernel taps per pixel, then drains them through ReLU
module sfu_accum #(
  parameter int psum_bw = 16,
  parameter int col = 8,
  parameter int depth = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [3:0]                   num_taps,
  input  logic [$clog2(depth):0]       num_pix,
  input  logic [psum_bw*col-1:0]       in_psum,
  input  logic                         in_valid,
  output logic                         ofifo_rd,
  output logic [psum_bw*col-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int aw = $clog2(depth);
  localparam int pw = aw + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] tap, taps;
  logic [pw-1:0] pix, pixs, didx;
  logic pop, fire, last_pix, last_tap, last_drain;
  logic [psum_bw*col-1:0] acc [depth];
  logic [psum_bw*col-1:0] acc_rd, acc_dr, acc_nx, relu;
  assign pop = state == ACCUM && in_valid;
  assign fire = state == DRAIN && out_ready;
  assign last_pix = pix == pixs - 1'b1;
  assign last_tap = tap == taps - 1'b1;
  assign last_drain = didx == pixs - 1'b1;
  assign acc_rd = acc[pix[aw-1:0]];
  assign acc_dr = acc[didx[aw-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: if (pop && last_pix && last_tap) state_nx = DRAIN;
      DRAIN: if (fire && last_drain) state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    ofifo_rd = pop;
    out_valid = state == DRAIN;
    out_data = state == DRAIN ? relu : '0;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tap <= '0;
      pix <= '0;
      didx <= '0;
      taps <= '0;
      pixs <= '0;
    end else begin
      if (state == IDLE && start) begin
        taps <= num_taps == 4'd0 ? 4'd1 : num_taps;
        pixs <= (num_pix == '0 || num_pix > pw'(depth)) ? pw'(depth) : num_pix;
        tap <= '0;
        pix <= '0;
        didx <= '0;
      end
      if (pop) begin
        pix <= last_pix ? '0 : pix + 1'b1;
        if (last_pix) tap <= tap + 1'b1;
      end
      if (fire) didx <= didx + 1'b1;
    end
  // storage only; contents stay invisible until written because out_data is gated by DRAIN
  always_ff @(posedge clk)
    if (pop) acc[pix[aw-1:0]] <= acc_nx;
  for (genvar k = 0; k < col; k++) begin : g_lane
    logic [psum_bw-1:0] a, b, d;
    logic [psum_bw:0] s;
    assign a = acc_rd[psum_bw*k +: psum_bw];
    assign b = in_psum[psum_bw*k +: psum_bw];
    assign d = acc_dr[psum_bw*k +: psum_bw];
    assign s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    assign acc_nx[psum_bw*k +: psum_bw] = tap == 4'd0 ? b :
      (s[psum_bw] ^ s[psum_bw-1]) ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}} : s[psum_bw-1:0];
    assign relu[psum_bw*k +: psum_bw] = d[psum_bw-1] ? '0 : d;
  end
endmodule

// File: tb/tb_sfu_accum.sv
// tb_sfu_accum: directed table, corner sequences and randomized passes against a per-pixel reference model
module tb_sfu_accum;
  logic clk = 0;
  logic reset, start, in_valid, out_ready;
  logic [3:0] num_taps;
  logic [4:0] num_pix;
  logic [127:0] in_psum, out_data;
  logic ofifo_rd, out_valid, busy, done;
  int checks = 0, failures = 0;
  logic [127:0] data [240];
  logic [127:0] expd [16];

  typedef struct {
    int nt;
    int np;
    int n;
    logic [127:0] pop [4];
    logic [127:0] res [2];
  } vec_t;
  vec_t tv [4];

  sfu_accum #(.psum_bw(16), .col(8), .depth(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_taps(num_taps), .num_pix(num_pix),
    .in_psum(in_psum), .in_valid(in_valid), .ofifo_rd(ofifo_rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [127:0] rep(input int v);
    logic [15:0] x;
    x = v[15:0];
    return {8{x}};
  endfunction

  function automatic logic [127:0] rnd_row();
    logic [127:0] r;
    for (int k = 0; k < 8; k++) begin
      int v;
      v = ($urandom % 2) ? int'($urandom % 65536) - 32768 : int'($urandom_range(0, 200)) - 100;
      r[k*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  // pop i carries tap i/enp, pixel i%enp; each pixel sums its taps with clamping, then ReLU
  function automatic void model(input int ent, input int enp);
    for (int p = 0; p < enp; p++)
      for (int k = 0; k < 8; k++) begin
        int a;
        a = 0;
        for (int t = 0; t < ent; t++) begin
          logic signed [15:0] s;
          s = data[t*enp + p][k*16 +: 16];
          a = (t == 0) ? int'(s) : a + int'(s);
          if (a > 32767) a = 32767;
          if (a < -32768) a = -32768;
        end
        expd[p][k*16 +: 16] = a < 0 ? 16'd0 : a[15:0];
      end
  endfunction

  // mode: 0 ready held high, 1 random ready, 2 ready low 5 cycles on row 1
  task automatic do_pass(input int nt, input int np, input bit gaps, input bit smid, input int mode);
    int ent, enp, n, i, cyc, r, w, hold, pops;
    bit rdy;
    ent = (nt == 0) ? 1 : nt;
    enp = (np == 0 || np > 16) ? 16 : np;
    n = ent * enp;
    pops = 0;
    start = 1;
    num_taps = nt[3:0];
    num_pix = np[4:0];
    in_valid = 0;
    out_ready = 0;
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 0;
    #1 chk("accum_busy", busy, 1);
    i = 0;
    cyc = 0;
    while (i < n) begin
      if (gaps && cyc % 2 == 1) begin
        in_valid = 0;
        in_psum = rnd_row();
      end else begin
        in_valid = 1;
        in_psum = data[i];
      end
      start = smid && cyc == 1;
      num_taps = 4'($urandom);
      num_pix = 5'($urandom);
      #1;
      chk("accum_rd", ofifo_rd, in_valid);
      chk("accum_ovalid", out_valid, 0);
      chk("accum_odata", out_data, 0);
      if (ofifo_rd) pops++;
      if (in_valid) i++;
      cyc++;
      @(negedge clk);
    end
    start = 0;
    r = 0;
    w = 0;
    hold = 0;
    while (r < enp && w < 2000) begin
      rdy = mode == 1 ? 1'($urandom) : (mode == 2 && r == 1 && hold < 5) ? 1'b0 : 1'b1;
      if (!rdy) hold++;
      out_ready = rdy;
      in_valid = 1'($urandom);
      #1;
      chk("drain_valid", out_valid, 1);
      chk($sformatf("drain_row%0d", r), out_data, expd[r]);
      chk("drain_rd", ofifo_rd, 0);
      chk("drain_done", done, 0);
      if (rdy) r++;
      w++;
      @(negedge clk);
    end
    if (w >= 2000) chk("drain_timeout", 1, 0);
    in_valid = 0;
    out_ready = 1'($urandom);
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_ovalid", out_valid, 0);
    chk("done_odata", out_data, 0);
    @(negedge clk);
    #1;
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("pop_count", pops, n);
    if (mode == 2 && enp > 1) chk("hold_cycles", hold, 5);
    @(negedge clk);
  endtask

  initial begin
    reset = 0;
    start = 0;
    in_valid = 0;
    out_ready = 0;
    num_taps = 0;
    num_pix = 0;
    in_psum = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", ofifo_rd, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    tv[0].nt = 2; tv[0].np = 2; tv[0].n = 4;
    tv[0].pop[0] = rep(5); tv[0].pop[1] = rep(7); tv[0].pop[2] = rep(1); tv[0].pop[3] = rep(-2);
    tv[0].res[0] = rep(6); tv[0].res[1] = rep(5);
    tv[1].nt = 2; tv[1].np = 1; tv[1].n = 2;
    tv[1].pop[0] = rep(30000); tv[1].pop[1] = rep(10000); tv[1].pop[2] = 0; tv[1].pop[3] = 0;
    tv[1].res[0] = rep(32767); tv[1].res[1] = 0;
    tv[2].nt = 2; tv[2].np = 1; tv[2].n = 2;
    tv[2].pop[0] = rep(-30000); tv[2].pop[1] = rep(-10000); tv[2].pop[2] = 0; tv[2].pop[3] = 0;
    tv[2].res[0] = rep(0); tv[2].res[1] = 0;
    tv[3].nt = 1; tv[3].np = 1; tv[3].n = 1;
    tv[3].pop[0] = 128'h0000_0000_0000_0000_0000_0000_0004_FFFD; tv[3].pop[1] = 0;
    tv[3].pop[2] = 0; tv[3].pop[3] = 0;
    tv[3].res[0] = 128'h0000_0000_0000_0000_0000_0000_0004_0000; tv[3].res[1] = 0;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < tv[v].n; i++) data[i] = tv[v].pop[i];
      for (int p = 0; p < tv[v].np; p++) expd[p] = tv[v].res[p];
      do_pass(tv[v].nt, tv[v].np, 0, 0, 0);
    end

    for (int i = 0; i < 8; i++) data[i] = rnd_row();
    model(2, 4);
    do_pass(2, 4, 0, 0, 2);

    for (int i = 0; i < 15; i++) data[i] = rnd_row();
    model(3, 5);
    do_pass(3, 5, 0, 0, 0);
    do_pass(3, 5, 1, 1, 0);

    // abort mid-pass: reset drops between edges with a pop presented
    start = 1;
    num_taps = 2;
    num_pix = 4;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_psum = rnd_row();
      @(negedge clk);
    end
    in_valid = 1;
    #1 chk("pre_abort_rd", ofifo_rd, 1);
    reset = 0;
    #1;
    chk("abort_rd", ofifo_rd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovalid", out_valid, 0);
    chk("abort_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("abort_hold_done", done, 0);
    end
    in_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    data[0] = rep(9);
    expd[0] = rep(9);
    do_pass(1, 1, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      int nt, np, ent, enp;
      nt = $urandom_range(0, 15);
      np = $urandom_range(0, 31);
      ent = (nt == 0) ? 1 : nt;
      enp = (np == 0 || np > 16) ? 16 : np;
      for (int i = 0; i < ent * enp; i++) data[i] = rnd_row();
      model(ent, enp);
      do_pass(nt, np, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sfu_accum.md
Name: sfu_accum

Overview:
Special-function stage directly downstream of the corelet's output FIFO. It pops per-column partial sums from the OFIFO and accumulates them across kernel taps into an on-chip accumulator indexed by output pixel. When every tap has been accumulated, it applies ReLU and streams one result row per pixel to the psum-memory writeback path over a valid/ready handshake.

Parameters:
psum_bw, 16, width of one signed two's-complement psum lane
col, 8, number of lanes (array columns) per row
depth, 16, accumulator entries (maximum output pixels per pass); power of 2

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a pass; sampled only in IDLE
num_taps  input  4  kernel taps per pass; latched on start; 0 is treated as 1
num_pix  input  $clog2(depth)+1  pixels per pass; latched on start; 0 or any value above depth is treated as depth
in_psum  input  psum_bw*col  OFIFO head data; lane k is bits [psum_bw*(k+1)-1 : psum_bw*k]
in_valid  input  1  OFIFO head valid (the OFIFO o_valid signal)
ofifo_rd  output  1  pop strobe to the OFIFO
out_data  output  psum_bw*col  ReLU'd accumulated row
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE; tap, pix and drain_idx counters go to 0; latched configuration goes to 0. Outputs while in reset: ofifo_rd=0, out_valid=0, out_data=0, busy=0, done=0. Accumulator contents are undefined after reset; no output may expose them before they are written.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: when start=1, latch the normalised num_taps and num_pix, clear the counters and move to ACCUM. If start=0, stay in IDLE.
- ACCUM:
  - ofifo_rd = in_valid (combinational). There is no stall: every valid head is popped in the cycle it is presented.
  - On each pop, lane by lane: if tap==0, acc[pix] = in_psum. Otherwise acc[pix] = sat(acc[pix] + in_psum).
  - sat clamps the signed result to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. Compute the sum at psum_bw+1 bits, then clamp.
  - Ordering: pix increments on each pop. When pix reaches num_pix-1, pix wraps to 0 and tap increments.
  - The pop with tap==num_taps-1 and pix==num_pix-1 moves the FSM to DRAIN with drain_idx=0.
  - A cycle with in_valid=0 changes nothing.
- DRAIN:
  - out_valid=1 and ofifo_rd=0.
  - out_data = relu(acc[drain_idx]) per lane: a negative lane outputs 0, any other lane passes through unchanged.
  - On out_valid && out_ready, drain_idx increments.
  - The handshake on drain_idx==num_pix-1 moves the FSM to DONE.
  - With out_ready=0, out_data and out_valid hold stable.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE. busy=0 in the cycle after DONE.
- In any state except DRAIN, out_valid=0 and out_data is forced to 0.
- start is ignored outside IDLE.
- Reset asserted mid-pass aborts immediately to IDLE. No done pulse is generated. Data still in the OFIFO is not drained by this block.
- Latency:
  - One pop is accumulated per cycle.
  - The first out_valid appears the cycle after the final pop.
  - With out_ready held high, one row drains per cycle.

Test Plan:
- num_taps=2, num_pix=2. Pop rows with all lanes 5, 7, 1, -2 (tap0 pix0, tap0 pix1, tap1 pix0, tap1 pix1). Expect out rows 6 and 5 on every lane, then a single done pulse.
- Saturation with num_taps=2, num_pix=1: pops 30000 then 10000 give out 32767. Pops -30000 then -10000 give out 0 (the sum saturates to -32768, then ReLU clamps it).
- Mixed lanes: lane0=-3 and lane1=4 with num_taps=1, num_pix=1. Expect out lane0=0 and lane1=4, and ofifo_rd high for exactly one cycle.
- Backpressure: hold out_ready=0 for 5 cycles during DRAIN. Expect out_data and out_valid stable throughout and no drain_idx advance. Release and confirm all num_pix rows arrive in order.
- in_valid gaps in ACCUM: toggle in_valid every other cycle. Results must match the gap-free run. Pulse start mid-pass and confirm it is ignored.
- Drop reset low in ACCUM after 3 pops. Expect ofifo_rd=0, busy=0 and out_valid=0 asynchronously, with no done pulse. A fresh start with num_taps=1, num_pix=1 and input 9 must produce output 9.
